// File: rtl/wheel_rev_meter.sv
// wheel_rev_meter
//   Turns one-cycle wheel revolution pulses into a revolution interval in
//   milliseconds, a revolution odometer and a moving flag for the
//   speed/distance display.
//
//   A free-running prescaler makes a 1 ms strobe. The prescaler is re-phased
//   on every accepted revolution, so each interval starts on a clean ms
//   boundary. Intervals shorter than MIN_PERIOD_MS are treated as sensor
//   glitches and dropped. If no accepted revolution arrives for TIMEOUT_MS,
//   the wheel is declared stopped.
//
//   Build option: define SPEED_AVG_EN to report the mean of the last four
//   accepted intervals instead of the raw interval. In that build an
//   accepted revolution reports two cycles later instead of one. A stop
//   report is still one cycle after the timeout.
//
// Ports
//   clk           in   system clock
//   rst           in   asynchronous reset, active low
//   rev_tick      in   one-cycle revolution pulse (debounced)
//   clear_odo     in   synchronous odometer clear, sampled every cycle
//   period_ms     out  last reported interval in ms, 0 = stopped
//   period_valid  out  one-cycle strobe whenever period_ms is written
//   moving        out  high while a steady interval is being measured
//   rev_count     out  accepted revolutions since reset/clear (wraps)
//
// State table
//   ST_STOP  | wheel stopped, waiting for a revolution to arm the reference
//   ST_FIRST | reference revolution held, first interval not measured yet
//   ST_RUN   | intervals being reported, wheel moving

module wheel_rev_meter #(
  parameter int TICK_DIV      = 100_000,
  parameter int PERIOD_W      = 16,
  parameter int TIMEOUT_MS    = 3000,
  parameter int MIN_PERIOD_MS = 20,
  parameter int ODO_W         = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rev_tick,
  input  logic                clear_odo,
  output logic [PERIOD_W-1:0] period_ms,
  output logic                period_valid,
  output logic                moving,
  output logic [ODO_W-1:0]    rev_count
);

  localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0]     PS_LAST   = PS_W'(TICK_DIV - 1);
  localparam logic [PERIOD_W-1:0] TIMEOUT_P = PERIOD_W'(TIMEOUT_MS);
  localparam logic [PERIOD_W-1:0] MIN_P     = PERIOD_W'(MIN_PERIOD_MS);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_FIRST = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PS_W-1:0]     prescaler_q, prescaler_d;
  logic [PERIOD_W-1:0] ms_cnt_q, ms_cnt_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                period_valid_q, period_valid_d;
  logic                moving_q, moving_d;
  logic [ODO_W-1:0]    rev_count_q, rev_count_d;

  logic                ms_strobe;
  logic [PERIOD_W-1:0] ms_now;
  logic                timeout_hit;
  logic                accept;
  logic                meas_valid;
  logic                tmo_evt;
  logic                run_tmo;

`ifdef SPEED_AVG_EN
  logic [PERIOD_W-1:0] hist_q [4];
  logic [PERIOD_W-1:0] hist_d [4];
  logic                avg_pend_q, avg_pend_d;
  logic [PERIOD_W+1:0] hist_sum;
  logic [PERIOD_W-1:0] hist_avg;
`endif

  // ms_now is the elapsed count including a strobe landing in this very
  // cycle. Without that, a revolution coinciding with the strobe would read
  // one ms short, and the timeout and the revolution would see different
  // counts in the same cycle.
  always_comb begin
    ms_strobe   = (prescaler_q == PS_LAST);
    ms_now      = ms_cnt_q;
    if ((state_q != ST_STOP) && ms_strobe && (ms_cnt_q != TIMEOUT_P)) begin
      ms_now = ms_cnt_q + PERIOD_W'(1);
    end
    timeout_hit = (state_q != ST_STOP) && (ms_now == TIMEOUT_P);
    accept      = rev_tick && ((state_q == ST_STOP) || (ms_now >= MIN_P));
    meas_valid  = accept && (state_q != ST_STOP);
    // An acceptable revolution in the timeout cycle takes priority.
    tmo_evt     = timeout_hit && !accept;
    run_tmo     = tmo_evt && (state_q == ST_RUN);
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_STOP;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_STOP: begin
        if (accept) state_d = ST_FIRST;
      end
      ST_FIRST: begin
        if (accept)       state_d = ST_RUN;
        else if (tmo_evt) state_d = ST_STOP;
      end
      ST_RUN: begin
        if (tmo_evt) state_d = ST_STOP;
      end
      default: state_d = ST_STOP;
    endcase
  end

`ifdef SPEED_AVG_EN
  always_comb begin
    hist_sum = {2'b00, hist_q[0]} + {2'b00, hist_q[1]}
             + {2'b00, hist_q[2]} + {2'b00, hist_q[3]};
    hist_avg = PERIOD_W'(hist_sum >> 2);
  end
`endif

  // Outputs and datapath
  always_comb begin
    prescaler_d = ms_strobe ? '0 : prescaler_q + PS_W'(1);
    if (accept) prescaler_d = '0;

    ms_cnt_d = ms_now;
    if ((state_d == ST_STOP) || accept) ms_cnt_d = '0;

    rev_count_d = rev_count_q;
    if (accept)    rev_count_d = rev_count_q + ODO_W'(1);
    if (clear_odo) rev_count_d = '0;

    moving_d = (state_d == ST_RUN);

    period_d       = period_q;
    period_valid_d = 1'b0;

`ifdef SPEED_AVG_EN
    for (int i = 0; i < 4; i++) hist_d[i] = hist_q[i];
    avg_pend_d = meas_valid;
    if (tmo_evt) begin
      for (int i = 0; i < 4; i++) hist_d[i] = '0;
    end else if (meas_valid) begin
      if (state_q == ST_FIRST) begin
        // First interval after a stop seeds the whole window so the
        // average starts at the real speed instead of ramping up from 0.
        for (int i = 0; i < 4; i++) hist_d[i] = ms_now;
      end else begin
        for (int i = 3; i > 0; i--) hist_d[i] = hist_q[i-1];
        hist_d[0] = ms_now;
      end
    end
    if (run_tmo) begin
      period_d       = '0;
      period_valid_d = 1'b1;
    end else if (avg_pend_q) begin
      period_d       = hist_avg;
      period_valid_d = 1'b1;
    end
`else
    if (run_tmo) begin
      period_d       = '0;
      period_valid_d = 1'b1;
    end else if (meas_valid) begin
      period_d       = ms_now;
      period_valid_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescaler_q    <= '0;
      ms_cnt_q       <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      moving_q       <= 1'b0;
      rev_count_q    <= '0;
    end else begin
      prescaler_q    <= prescaler_d;
      ms_cnt_q       <= ms_cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      moving_q       <= moving_d;
      rev_count_q    <= rev_count_d;
    end
  end

`ifdef SPEED_AVG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) hist_q[i] <= '0;
      avg_pend_q <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) hist_q[i] <= hist_d[i];
      avg_pend_q <= avg_pend_d;
    end
  end
`endif

  assign period_ms    = period_q;
  assign period_valid = period_valid_q;
  assign moving       = moving_q;
  assign rev_count    = rev_count_q;

endmodule

// File: tb/tb_wheel_rev_meter.sv
module tb_wheel_rev_meter;

  localparam int TICK_DIV      = 10;
  localparam int PERIOD_W      = 8;
  localparam int TIMEOUT_MS    = 50;
  localparam int MIN_PERIOD_MS = 3;
  localparam int ODO_W         = 4;
  localparam int ODO_MOD       = 1 << ODO_W;
`ifdef SPEED_AVG_EN
  localparam int ACC_LAT = 2;
  localparam bit AVG     = 1'b1;
`else
  localparam int ACC_LAT = 1;
  localparam bit AVG     = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                rev_tick = 1'b0;
  logic                clear_odo = 1'b0;
  logic [PERIOD_W-1:0] period_ms;
  logic                period_valid;
  logic                moving;
  logic [ODO_W-1:0]    rev_count;

  wheel_rev_meter #(
    .TICK_DIV(TICK_DIV), .PERIOD_W(PERIOD_W), .TIMEOUT_MS(TIMEOUT_MS),
    .MIN_PERIOD_MS(MIN_PERIOD_MS), .ODO_W(ODO_W)
  ) dut (
    .clk(clk), .rst(rst), .rev_tick(rev_tick), .clear_odo(clear_odo),
    .period_ms(period_ms), .period_valid(period_valid),
    .moving(moving), .rev_count(rev_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard of expected period reports: value and the cycle it must appear.
  typedef struct { int val; int due; } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  // Reference model: elapsed ms derived by division from the cycle of the
  // last accepted revolution.
  int m_st;   // 0 stop, 1 first, 2 run
  int m_last;
  int m_rev;
  int m_hist[4];

  task automatic model_reset();
    m_st = 0; m_last = 0; m_rev = 0;
    for (int i = 0; i < 4; i++) m_hist[i] = 0;
    sb.delete();
  endtask

  task automatic push_period(input int ms, input bit first, input int c);
    int v;
    v = ms;
    if (AVG) begin
      if (first) for (int i = 0; i < 4; i++) m_hist[i] = ms;
      else begin
        for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = ms;
      end
      v = (m_hist[0] + m_hist[1] + m_hist[2] + m_hist[3]) / 4;
    end
    sb.push_back('{v, c + ACC_LAT});
  endtask

  task automatic model_step(input bit t, input bit clr, input int c);
    int ms;
    bit acc;
    acc = 1'b0;
    ms  = (c - m_last) / TICK_DIV;
    if (ms > TIMEOUT_MS) ms = TIMEOUT_MS;
    if (m_st == 0) begin
      if (t) begin acc = 1'b1; m_st = 1; end
    end else if (t && ms >= MIN_PERIOD_MS) begin
      acc = 1'b1;
      push_period(ms, m_st == 1, c);
      m_st = 2;
    end else if (ms == TIMEOUT_MS) begin
      if (m_st == 2) sb.push_back('{0, c + 1});
      for (int i = 0; i < 4; i++) m_hist[i] = 0;
      m_st = 0;
    end
    if (acc) m_last = c;
    if (clr) m_rev = 0;
    else if (acc) m_rev = (m_rev + 1) % ODO_MOD;
  endtask

  // Inputs are driven 1 time unit after a rising edge and held one cycle.
  task automatic drive(input bit t, input bit clr);
    rev_tick  = t;
    clear_odo = clr;
    model_step(t, clr, cyc);
    @(posedge clk); #1;
    rev_tick  = 1'b0;
    clear_odo = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    check("reset_period_ms", int'(period_ms), 0);
    check("reset_period_valid", int'(period_valid), 0);
    check("reset_moving", int'(moving), 0);
    check("reset_rev_count", int'(rev_count), 0);
  endtask

  // Period monitor: every scoreboard entry must show up exactly at its due
  // cycle with the right value; a strobe at any other time is spurious.
  always @(negedge clk) begin
    if (rst) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        mon_e = sb.pop_front();
        check("period_valid_at_due", int'(period_valid), 1);
        if (period_valid) check("period_ms", int'(period_ms), mon_e.val);
      end else if (period_valid) begin
        check("spurious_period_valid", int'(period_valid), 0);
      end
    end
  end

  typedef struct { int gap; bit clr; int exp_rev; bit exp_mov; } row_t;
  row_t rows[11];

  initial begin
    rows[0]  = '{5,   1'b0, 1, 1'b0};  // arm from stop
    rows[1]  = '{200, 1'b0, 2, 1'b1};  // 20 ms
    rows[2]  = '{20,  1'b0, 2, 1'b1};  // 2 ms: glitch
    rows[3]  = '{80,  1'b0, 3, 1'b1};  // 10 ms
    rows[4]  = '{3,   1'b0, 3, 1'b1};  // 0 ms: glitch
    rows[5]  = '{30,  1'b0, 4, 1'b1};  // 3 ms: exactly the minimum
    rows[6]  = '{29,  1'b0, 4, 1'b1};  // 2 ms: glitch
    rows[7]  = '{471, 1'b0, 5, 1'b1};  // 50 ms: tick beats timeout
    rows[8]  = '{600, 1'b0, 6, 1'b0};  // timeout at 500, then re-arm
    rows[9]  = '{100, 1'b1, 0, 1'b1};  // clear wins over accepted tick
    rows[10] = '{100, 1'b0, 1, 1'b1};

    do_reset();

    foreach (rows[r]) begin
      idle(rows[r].gap - 1);
      drive(1'b1, rows[r].clr);
      check($sformatf("row%0d_rev_count", r), int'(rev_count), rows[r].exp_rev);
      check($sformatf("row%0d_moving", r), int'(moving), int'(rows[r].exp_mov));
    end
    idle(2);
    check("clear_row_period_ms", int'(period_ms), AVG ? 10 : 10);

    // Odometer wrap: 17 accepted ticks at 100-cycle spacing.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      if (i > 0) idle(99);
      drive(1'b1, 1'b0);
      check($sformatf("wrap%0d_rev_count", i), int'(rev_count), (i + 1) % ODO_MOD);
    end

    // Intervals 10,10,10,30 ms; raw build reports 30, averaging build 15.
    do_reset();
    drive(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin idle(99); drive(1'b1, 1'b0); end
    idle(299);
    drive(1'b1, 1'b0);
    idle(2);
    check("profile_last_period", int'(period_ms), AVG ? 15 : 30);

    // rev_tick held for three cycles: only the first is accepted.
    do_reset();
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    check("held_rev_count", int'(rev_count), 1);
    check("held_moving", int'(moving), 0);
    idle(199);
    drive(1'b1, 1'b0);
    check("held_next_rev_count", int'(rev_count), 2);
    check("held_next_moving", int'(moving), 1);

    // Reset in the middle of a measurement; next tick only re-arms.
    drive(1'b1, 1'b0);
    idle(150);
    do_reset();
    idle(50);
    drive(1'b1, 1'b0);
    check("rearm_rev_count", int'(rev_count), 1);
    check("rearm_moving", int'(moving), 0);
    idle(199);
    drive(1'b1, 1'b0);
    check("rearm2_rev_count", int'(rev_count), 2);
    check("rearm2_moving", int'(moving), 1);

    // Clear with no tick.
    drive(1'b0, 1'b1);
    check("clear_only_rev_count", int'(rev_count), 0);

    // Let every outstanding report reach its due cycle.
    idle(5);
    check("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
